id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- Pipeline register between instruction decode and execute.
- Captures the decoder control word plus operand and immediate data on each clock.
- Contains load-use hazard detection. When a hazard is found it stalls the fetch/decode stages for one cycle and inserts a bubble into EX.
- Accepts a flush from EX branch/jump resolution and a freeze from the memory subsystem.

Parameters:
- XLEN, 32, data path width
- RADDR, 5, register address width

Ports:
- clk  in  1  clock, rising-edge
- reset  in  1  synchronous, active-high
- freeze  in  1  hold all EX registers unchanged
- flush  in  1  squash the instruction entering EX (taken branch/jump)
- id_regDst, id_jump, id_memRead, id_memToReg, id_memWrite, id_aluSrc, id_regWrite  in  1 each  decoder control bits
- id_branch  in  2  BRANCH_OFF/BRANCH_BEQ/BRANCH_BNE
- id_arctrl  in  4  ALU op class (ARCTRL_*)
- id_pcPlus4  in  XLEN  PC+4 of the decoded instruction
- id_rd1, id_rd2  in  XLEN  register file read data
- id_imm  in  XLEN  sign-extended immediate
- id_rs, id_rt, id_rd  in  RADDR  register specifiers
- id_funct  in  6  funct field
- stall  out  1  combinational; hold PC and IF/ID register
- ex_valid  out  1  EX slot holds a real instruction
- ex_ctrl  out  16  registered control word (id_ex_ctrl_t)
- ex_pcPlus4, ex_rd1, ex_rd2, ex_imm  out  XLEN  registered data
- ex_rs, ex_rt, ex_rd  out  RADDR  registered specifiers
- ex_funct  out  6  registered funct

Behaviour:
- Reset values:
  - all ex_* outputs 0.
  - ex_ctrl.branch = BRANCH_OFF.
  - ex_ctrl.arctrl = ARCTRL_ZERO.
  - ex_valid = 0.
  - stall = 0, since it is derived from reset-cleared state.
- Latency: 1 cycle, ID inputs to ex_* outputs.
- hazard = ex_valid & ex_ctrl.memRead & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)).
  - The comparison is conservative: it applies regardless of whether the instruction actually reads rt.
- stall = hazard & ~freeze & ~flush.
- Per-edge priority, highest first:
  1. reset: load reset values.
  2. flush: ex_valid←0, control word←bubble; data registers load normally.
  3. freeze: every register holds.
  4. hazard: ex_valid←0, control word←bubble; data registers hold.
  5. otherwise: load all ID inputs, ex_valid←1.
- Bubble word: all control bits 0, branch = BRANCH_OFF, arctrl = ARCTRL_ZERO.
- A load-use stall lasts exactly 1 cycle, because the bubble clears ex_ctrl.memRead. The second cycle therefore loads the stalled instruction.
- Back-to-back LW→LW→use: each pair is detected independently; there is no multi-cycle state.
- Flush during a hazard: flush wins and stall = 0. The fetch redirect overrides the hold.
- Freeze during a hazard: stall = 0 and everything holds. The hazard re-evaluates after the freeze releases.
- Reset mid-stall: the next cycle has ex_valid = 0 and stall = 0.

Optional Feature:
- Macro: ID_EX_HAZARD_STATS_EN.
- When defined, adds outputs stall_count [31:0] and flush_count [31:0].
  - They count edges where the hazard and flush priority branches are taken, respectively.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- When not defined, these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- MIPSConstants package: add typedef struct packed id_ex_ctrl_t with these fields:
  - regDst, jump, branch[1:0], memRead, memToReg, arctrl[3:0], memWrite, aluSrc, regWrite, pad[2:0] (16 bits total).
- MIPSConstants package: add constant ID_EX_BUBBLE of that type.
- Existing BRANCH_* and ARCTRL_* constants are reused.
- One sub-module: load_use_detector. It is purely combinational: ex_valid, ex_memRead, ex_rt, id_rs, id_rt → hazard.

Test Plan:
- Reset with all ID inputs nonzero → next edge: ex_valid=0, ex_ctrl==ID_EX_BUBBLE, all data 0, stall=0.
- ADDI $3,$1,5 presented (aluSrc=1, regWrite=1, arctrl=ARCTRL_ADD, imm=5) → one edge later: ex_valid=1, ex_ctrl matches, ex_imm=5, ex_rt=3.
- LW $5 in EX, then ADD with id_rs=5 → stall=1 for 1 cycle, EX gets a bubble (ex_valid=0); next edge: ADD in EX with rs=5, stall=0.
- LW $0 in EX, id_rs=0 → stall=0, no bubble.
- LW $5 in EX, id_rt=5, flush=1 in the same cycle → stall=0, ex_valid=0; next cycle no hazard.
- freeze=1 for 3 cycles with changing ID inputs → ex_* unchanged. With ID_EX_HAZARD_STATS_EN defined, 2 hazards and 1 flush → stall_count=2, flush_count=1.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// MIPSConstants slice: branch/ALU codes, the ID/EX control word, its bubble value,
// and the action select used by the ID/EX register.
package MIPSConstants;

   localparam int unsigned BRANCH_W = 2;
   localparam int unsigned ARCTRL_W = 4;
   localparam int unsigned FUNCT_W  = 6;
   localparam int unsigned CTRL_W   = 16;
   localparam int unsigned STAT_W   = 32;

   localparam logic [BRANCH_W-1:0] BRANCH_OFF = 2'd0;
   localparam logic [BRANCH_W-1:0] BRANCH_BEQ = 2'd1;
   localparam logic [BRANCH_W-1:0] BRANCH_BNE = 2'd2;

   localparam logic [ARCTRL_W-1:0] ARCTRL_ZERO  = 4'd0;
   localparam logic [ARCTRL_W-1:0] ARCTRL_ADD   = 4'd1;
   localparam logic [ARCTRL_W-1:0] ARCTRL_SUB   = 4'd2;
   localparam logic [ARCTRL_W-1:0] ARCTRL_AND   = 4'd3;
   localparam logic [ARCTRL_W-1:0] ARCTRL_OR    = 4'd4;
   localparam logic [ARCTRL_W-1:0] ARCTRL_XOR   = 4'd5;
   localparam logic [ARCTRL_W-1:0] ARCTRL_NOR   = 4'd6;
   localparam logic [ARCTRL_W-1:0] ARCTRL_SLT   = 4'd7;
   localparam logic [ARCTRL_W-1:0] ARCTRL_LUI   = 4'd8;
   localparam logic [ARCTRL_W-1:0] ARCTRL_FUNCT = 4'd9;

   // Control word carried from ID into EX; pad keeps it at 16 bits.
   typedef struct packed {
      logic                regDst;
      logic                jump;
      logic [BRANCH_W-1:0] branch;
      logic                memRead;
      logic                memToReg;
      logic [ARCTRL_W-1:0] arctrl;
      logic                memWrite;
      logic                aluSrc;
      logic                regWrite;
      logic [2:0]          pad;
   } id_ex_ctrl_t;

   localparam id_ex_ctrl_t ID_EX_BUBBLE = '{
      regDst:   1'b0,
      jump:     1'b0,
      branch:   BRANCH_OFF,
      memRead:  1'b0,
      memToReg: 1'b0,
      arctrl:   ARCTRL_ZERO,
      memWrite: 1'b0,
      aluSrc:   1'b0,
      regWrite: 1'b0,
      pad:      3'b000
   };

   // What the ID/EX register does on the coming edge, in priority order.
   typedef enum logic [2:0] {
      ACT_RESET  = 3'd0,
      ACT_FLUSH  = 3'd1,
      ACT_HOLD   = 3'd2,
      ACT_BUBBLE = 3'd3,
      ACT_LOAD   = 3'd4
   } ex_action_e;

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
   endfunction

endpackage

// File: rtl/id_ex_stage_load_use.sv
// Load-use hazard detector: a load in EX whose destination matches either
// source specifier of the instruction in ID. Purely combinational.
module load_use_detector #(
   parameter int unsigned RADDR = 5
) (
   input  logic             ex_valid,
   input  logic             ex_memRead,
   input  logic [RADDR-1:0] ex_rt,
   input  logic [RADDR-1:0] id_rs,
   input  logic [RADDR-1:0] id_rt,
   output logic             hazard
);

   // Conservative: rt is compared even when the ID instruction does not read it.
   assign hazard = ex_valid & ex_memRead & (ex_rt != '0) &
                   ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush and freeze handling.
// Optional ID_EX_HAZARD_STATS_EN adds saturating stall/flush edge counters.
module id_ex_stage
   import MIPSConstants::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned RADDR = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                freeze,
   input  logic                flush,
   input  logic                id_regDst,
   input  logic                id_jump,
   input  logic [BRANCH_W-1:0] id_branch,
   input  logic                id_memRead,
   input  logic                id_memToReg,
   input  logic [ARCTRL_W-1:0] id_arctrl,
   input  logic                id_memWrite,
   input  logic                id_aluSrc,
   input  logic                id_regWrite,
   input  logic [XLEN-1:0]     id_pcPlus4,
   input  logic [XLEN-1:0]     id_rd1,
   input  logic [XLEN-1:0]     id_rd2,
   input  logic [XLEN-1:0]     id_imm,
   input  logic [RADDR-1:0]    id_rs,
   input  logic [RADDR-1:0]    id_rt,
   input  logic [RADDR-1:0]    id_rd,
   input  logic [FUNCT_W-1:0]  id_funct,
   output logic                stall,
   output logic                ex_valid,
   output id_ex_ctrl_t         ex_ctrl,
   output logic [XLEN-1:0]     ex_pcPlus4,
   output logic [XLEN-1:0]     ex_rd1,
   output logic [XLEN-1:0]     ex_rd2,
   output logic [XLEN-1:0]     ex_imm,
   output logic [RADDR-1:0]    ex_rs,
   output logic [RADDR-1:0]    ex_rt,
   output logic [RADDR-1:0]    ex_rd,
   output logic [FUNCT_W-1:0]  ex_funct
`ifdef ID_EX_HAZARD_STATS_EN
   ,
   output logic [STAT_W-1:0]   stall_count,
   output logic [STAT_W-1:0]   flush_count
`endif
);

   logic        hazard;
   id_ex_ctrl_t id_ctrl;
   ex_action_e  action;

   load_use_detector #(
      .RADDR (RADDR)
   ) u_load_use (
      .ex_valid   (ex_valid),
      .ex_memRead (ex_ctrl.memRead),
      .ex_rt      (ex_rt),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .hazard     (hazard)
   );

   // A flush redirects fetch and a freeze holds everything, so neither needs the stall.
   assign stall = hazard & ~freeze & ~flush;

   // Pack the decoder bits into the EX control word.
   always_comb begin
      id_ctrl          = ID_EX_BUBBLE;
      id_ctrl.regDst   = id_regDst;
      id_ctrl.jump     = id_jump;
      id_ctrl.branch   = id_branch;
      id_ctrl.memRead  = id_memRead;
      id_ctrl.memToReg = id_memToReg;
      id_ctrl.arctrl   = id_arctrl;
      id_ctrl.memWrite = id_memWrite;
      id_ctrl.aluSrc   = id_aluSrc;
      id_ctrl.regWrite = id_regWrite;
   end

   // Per-edge priority: reset, flush, freeze, hazard, normal load.
   always_comb begin
      action = ACT_LOAD;
      if (reset) begin
         action = ACT_RESET;
      end else if (flush) begin
         action = ACT_FLUSH;
      end else if (freeze) begin
         action = ACT_HOLD;
      end else if (hazard) begin
         action = ACT_BUBBLE;
      end
   end

   // Control word and valid bit.
   always_ff @(posedge clk) begin
      case (action)
         ACT_RESET, ACT_FLUSH, ACT_BUBBLE: begin
            ex_valid <= 1'b0;
            ex_ctrl  <= ID_EX_BUBBLE;
         end
         ACT_LOAD: begin
            ex_valid <= 1'b1;
            ex_ctrl  <= id_ctrl;
         end
         default: begin
            ex_valid <= ex_valid;
            ex_ctrl  <= ex_ctrl;
         end
      endcase
   end

   // Data registers still load on a flush; only the control word is squashed.
   always_ff @(posedge clk) begin
      case (action)
         ACT_RESET: begin
            ex_pcPlus4 <= '0;
            ex_rd1     <= '0;
            ex_rd2     <= '0;
            ex_imm     <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rd      <= '0;
            ex_funct   <= '0;
         end
         ACT_FLUSH, ACT_LOAD: begin
            ex_pcPlus4 <= id_pcPlus4;
            ex_rd1     <= id_rd1;
            ex_rd2     <= id_rd2;
            ex_imm     <= id_imm;
            ex_rs      <= id_rs;
            ex_rt      <= id_rt;
            ex_rd      <= id_rd;
            ex_funct   <= id_funct;
         end
         default: begin
            ex_pcPlus4 <= ex_pcPlus4;
            ex_rd1     <= ex_rd1;
            ex_rd2     <= ex_rd2;
            ex_imm     <= ex_imm;
            ex_rs      <= ex_rs;
            ex_rt      <= ex_rt;
            ex_rd      <= ex_rd;
            ex_funct   <= ex_funct;
         end
      endcase
   end

`ifdef ID_EX_HAZARD_STATS_EN
   // Saturating counts of hazard-bubble and flush edges.
   always_ff @(posedge clk) begin
      if (action == ACT_RESET) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (action == ACT_BUBBLE) begin
            stall_count <= sat_inc(stall_count);
         end
         if (action == ACT_FLUSH) begin
            flush_count <= sat_inc(flush_count);
         end
      end
   end
`endif

endmodule
